// File: rtl/axi4_burst_sequencer_if.sv
// Command and beat channels of the AXI4 burst sequencer.
//   master : command source / beat consumer (agent queue and data path)
//   slave  : the sequencer itself
//   cmd_*  : one AW/AR command, valid/ready handshake
//   beat_* : per-beat record (address, index, last, lane range, error tags)
interface axi4_burst_sequencer_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
);
    localparam int unsigned LB = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;

    logic              beat_valid;
    logic              beat_ready;
    logic [ID_W-1:0]   beat_id;
    logic [ADDR_W-1:0] beat_addr;
    logic [7:0]        beat_idx;
    logic              beat_last;
    logic [LB-1:0]     beat_lane_lo;
    logic [LB-1:0]     beat_lane_hi;
    logic [4:0]        beat_err;

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  cmd_ready,
        input  beat_valid, beat_id, beat_addr, beat_idx, beat_last,
        input  beat_lane_lo, beat_lane_hi, beat_err,
        output beat_ready
    );

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output cmd_ready,
        output beat_valid, beat_id, beat_addr, beat_idx, beat_last,
        output beat_lane_lo, beat_lane_hi, beat_err,
        input  beat_ready
    );
endinterface

// File: rtl/axi4_burst_sequencer.sv
// Expands one AXI4 AW/AR command into per-beat records and tags every beat
// with the protocol-check result computed when the command was accepted.
//   aclk, areset : clock, synchronous active-high reset
//   bus (slave)  : cmd_* command channel in, beat_* record channel out;
//                  cmd_ready is combinational from beat_ready, all beat_*
//                  outputs are registered.
module axi4_burst_sequencer #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi4_burst_sequencer_if.slave  bus
);
    localparam int unsigned LB = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;
    // Address-advance rule; reserved bursts and illegal WRAP lengths walk as INCR.
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

    state_t            state;
    mode_t             mode_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] wmask_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        idx_q;
    logic              last_q;
    logic [LB-1:0]     lo_q;
    logic [LB-1:0]     hi_q;
    logic [4:0]        err_q;

    logic beat_fire;
    logic cmd_ready_c;
    logic cmd_fire;

    // Highest lane: low address bits with the sub-beat offset forced to ones.
    function automatic logic [LB-1:0] lane_hi_f(input logic [ADDR_W-1:0] a,
                                                input logic [2:0]        sz,
                                                input logic              sz_err);
        logic [LB-1:0] m;
        m = LB'((32'(1) << sz) - 32'(1));
        return sz_err ? {LB{1'b1}} : (a[LB-1:0] | m);
    endfunction

    assign beat_fire   = (state == S_BURST) && bus.beat_ready;
    assign cmd_ready_c = !areset && ((state == S_IDLE) || (beat_fire && last_q));
    assign cmd_fire    = bus.cmd_valid && cmd_ready_c;

    // Command decode and protocol checks, valid in the accept cycle.
    logic [ADDR_W-1:0] ld_bmask;
    logic [ADDR_W-1:0] ld_wmask;
    logic [16:0]       ld_span;
    logic [16:0]       ld_end;
    logic              ld_wrap_len_ok;
    logic [4:0]        ld_err;
    mode_t             ld_mode;

    always_comb begin
        ld_bmask       = (ADDR_W'(1) << bus.cmd_size) - ADDR_W'(1);
        ld_wmask       = ((ADDR_W'(bus.cmd_len) + ADDR_W'(1)) << bus.cmd_size) - ADDR_W'(1);
        ld_span        = (17'(bus.cmd_len) + 17'd1) << bus.cmd_size;
        ld_end         = 17'(bus.cmd_addr[11:0]) + ld_span;
        ld_wrap_len_ok = (bus.cmd_len == 8'd1) || (bus.cmd_len == 8'd3) ||
                         (bus.cmd_len == 8'd7) || (bus.cmd_len == 8'd15);
        ld_err         = '0;
        ld_err[0]      = (bus.cmd_burst == 2'd3);
        ld_err[1]      = (bus.cmd_burst == 2'd2) && !ld_wrap_len_ok;
        ld_err[2]      = (bus.cmd_burst == 2'd2) && ((bus.cmd_addr & ld_bmask) != '0);
        ld_err[3]      = ((bus.cmd_burst == 2'd1) || (bus.cmd_burst == 2'd3)) &&
                         (ld_end > 17'd4096);
        ld_err[4]      = (32'(1) << bus.cmd_size) > 32'(DATA_W / 8);
        ld_mode        = M_INCR;
        if (bus.cmd_burst == 2'd0) begin
            ld_mode = M_FIXED;
        end else if ((bus.cmd_burst == 2'd2) && ld_wrap_len_ok) begin
            ld_mode = M_WRAP;
        end
    end

    // Next beat address from the current one.
    logic [ADDR_W-1:0] nx_bmask;
    logic [ADDR_W-1:0] nx_addr;

    always_comb begin
        nx_bmask = (ADDR_W'(1) << size_q) - ADDR_W'(1);
        nx_addr  = addr_q;
        case (mode_q)
            M_INCR:  nx_addr = (addr_q & ~nx_bmask) + nx_bmask + ADDR_W'(1);
            M_WRAP:  nx_addr = (addr_q & ~wmask_q) |
                               ((addr_q + nx_bmask + ADDR_W'(1)) & wmask_q);
            default: nx_addr = addr_q;
        endcase
    end

    // State and registered beat record; a new command may reload on the last handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= S_IDLE;
            mode_q  <= M_FIXED;
            len_q   <= '0;
            size_q  <= '0;
            wmask_q <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= '0;
        end else if (cmd_fire) begin
            state   <= S_BURST;
            mode_q  <= ld_mode;
            len_q   <= bus.cmd_len;
            size_q  <= bus.cmd_size;
            wmask_q <= ld_wmask;
            id_q    <= bus.cmd_id;
            addr_q  <= bus.cmd_addr;
            idx_q   <= '0;
            last_q  <= (bus.cmd_len == 8'd0);
            lo_q    <= bus.cmd_addr[LB-1:0];
            hi_q    <= lane_hi_f(bus.cmd_addr, bus.cmd_size, ld_err[4]);
            err_q   <= ld_err;
        end else if (beat_fire) begin
            if (!last_q) begin
                addr_q <= nx_addr;
                idx_q  <= idx_q + 8'd1;
                last_q <= ((idx_q + 8'd1) == len_q);
                lo_q   <= nx_addr[LB-1:0];
                hi_q   <= lane_hi_f(nx_addr, size_q, err_q[4]);
            end else begin
                state  <= S_IDLE;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_c;
    assign bus.beat_valid   = (state == S_BURST);
    assign bus.beat_id      = id_q;
    assign bus.beat_addr    = addr_q;
    assign bus.beat_idx     = idx_q;
    assign bus.beat_last    = last_q;
    assign bus.beat_lane_lo = lo_q;
    assign bus.beat_lane_hi = hi_q;
    assign bus.beat_err     = err_q;
endmodule
